// File: rtl/sipo_if.sv
// sipo_if: serial line, frame configuration and received-word outputs of the UART receiver.
interface sipo_if;
  logic       rx;
  logic       data_length;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic [7:0] data_out;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;
  modport master (
    output rx, data_length, parity_type, stop_bits,
    input  data_out, rx_active, rx_done, parity_error, stop_error
  );
  modport slave (
    input  rx, data_length, parity_type, stop_bits,
    output data_out, rx_active, rx_done, parity_error, stop_error
  );
endinterface

// File: rtl/sipo.sv
// sipo: oversampled UART receiver with mid-bit sampling, optional parity and one/two stop bits.
module sipo #(
  parameter int OVERSAMPLE = 16
) (
  input logic   baud_clk,
  input logic   rst,
  sipo_if.slave bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t state, state_n;
  logic sync1, rx_s, armed;
  logic len_q, stop_q;
  logic [1:0] par_q;
  logic perr, serr;
  logic [TW-1:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg, data_q;
  logic done_q, perr_q, serr_q, rx_active_c;
  logic tick, mid, last_bit, is_stop, done, perr_n, serr_n;
  assign tick     = tcnt == T_END;
  assign mid      = tcnt == T_MID;
  assign last_bit = bcnt == {2'b11, len_q};
  assign is_stop  = state == STOP1 || state == STOP2;
  assign done     = tick && (state == STOP2 || (state == STOP1 && !stop_q));
  // par_q[0] set means odd parity: a sample equal to the data XOR is then the mismatch
  assign perr_n   = perr | (state == PARITY && tick && (rx_s ^ (^shreg) ^ par_q[0]));
  assign serr_n   = serr | (is_stop && tick && !rx_s);
  always_ff @(posedge baud_clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = armed && !rx_s ? START : IDLE;
      START:   if (mid) state_n = rx_s ? IDLE : DATA;
      DATA:    if (tick && last_bit) state_n = ^par_q ? PARITY : STOP1;
      PARITY:  if (tick) state_n = STOP1;
      STOP1:   if (tick) state_n = stop_q ? STOP2 : IDLE;
      STOP2:   if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb rx_active_c = state != IDLE;
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      armed  <= 1'b1;
      tcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      len_q  <= 1'b0;
      par_q  <= '0;
      stop_q <= 1'b0;
      perr   <= 1'b0;
      serr   <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      perr_q <= 1'b0;
      serr_q <= 1'b0;
    end else begin
      sync1  <= bus.rx;
      rx_s   <= sync1;
      done_q <= done;
      tcnt   <= (state == IDLE || (state == START ? mid : tick)) ? '0 : tcnt + 1'b1;
      perr   <= perr_n;
      serr   <= serr_n;
      if (state == IDLE && rx_s) armed <= 1'b1;
      if (state == IDLE && state_n == START) begin
        len_q  <= bus.data_length;
        par_q  <= bus.parity_type;
        stop_q <= bus.stop_bits;
        bcnt   <= '0;
        shreg  <= '0;
        perr   <= 1'b0;
        serr   <= 1'b0;
      end
      if (state == DATA && tick) begin
        shreg[bcnt] <= rx_s;
        bcnt        <= bcnt + 1'b1;
      end
      // a framing error disarms until the line is seen high, so a break gives one frame
      if (done) begin
        data_q <= shreg;
        perr_q <= perr_n;
        serr_q <= serr_n;
        armed  <= !serr_n;
      end
    end
  end
  assign bus.data_out     = data_q;
  assign bus.rx_done      = done_q;
  assign bus.parity_error = perr_q;
  assign bus.stop_error   = serr_q;
  assign bus.rx_active    = rx_active_c;
endmodule
